// File: rtl/note_seq_pkg.sv
// Shared types and default widths for the note sequencer.
// The optional loop feature is enabled by defining NOTE_SEQUENCER_LOOP_EN.
package note_seq_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int NOTE_W_DEF = 8;
   localparam int DUR_W_DEF  = 8;
   localparam int TEMPO_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_PLAY,
      ST_DONE
   } seq_state_e;

endpackage

// File: rtl/seq_tick_gen.sv
// Beat-unit tick generator: pulses once every max(tempo_i,1) enabled clocks.
// Tempo is compared live, so a new value applies at the next compare.
module seq_tick_gen
   import note_seq_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   input  logic               clr_i,
   input  logic [TEMPO_W-1:0] tempo_i,
   output logic               tick_o
);

   logic [TEMPO_W-1:0] cnt_q, cnt_d;
   logic [TEMPO_W-1:0] tempo_eff;
   logic               at_end;

   assign tempo_eff = (tempo_i == '0) ? TEMPO_W'(1) : tempo_i;
   // >= rather than == so a tempo lowered mid-count still wraps immediately.
   assign at_end    = (cnt_q >= tempo_eff - TEMPO_W'(1));
   assign tick_o    = en_i & ~clr_i & at_end;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = at_end ? '0 : cnt_q + TEMPO_W'(1);
      end
   end

   // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/note_sequencer.sv
// Note-table sequencer: fetches {dur, note} entries and plays each for dur beat units.
// Define NOTE_SEQUENCER_LOOP_EN to let loop_i restart the song at its end marker.
module note_sequencer
   import note_seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NOTE_W = NOTE_W_DEF,
   parameter int DUR_W  = DUR_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic                    stop_i,
   input  logic                    loop_i,
   input  logic [ADDR_W-1:0]       start_addr_i,
   input  logic [TEMPO_W-1:0]      tempo_i,
   output logic [ADDR_W-1:0]       rom_addr_o,
   input  logic [DUR_W+NOTE_W-1:0] rom_data_i,
   output logic [NOTE_W-1:0]       note_o,
   output logic                    note_on_o,
   output logic                    step_o,
   output logic                    busy_o,
   output logic                    done_o
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);

   seq_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic [DUR_W-1:0]  dur_q, dur_d;
   logic              step_q, step_d;
   logic              tick, tick_en, tick_clr;
   logic              end_song, loop_req;
   logic [DUR_W-1:0]  rom_dur;
   logic [NOTE_W-1:0] rom_note;

   assign {rom_dur, rom_note} = rom_data_i;

`ifdef NOTE_SEQUENCER_LOOP_EN
   assign loop_req = loop_i;
`else
   logic unused_loop;
   assign unused_loop = loop_i;
   assign loop_req    = 1'b0;
`endif

   assign tick_en  = (state_q == ST_PLAY);
   assign tick_clr = stop_i | (state_q != ST_PLAY);

   seq_tick_gen u_tick (
      .clk     (clk),
      .rst     (rst),
      .en_i    (tick_en),
      .clr_i   (tick_clr),
      .tempo_i (tempo_i),
      .tick_o  (tick)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      note_d   = note_q;
      dur_d    = dur_q;
      step_d   = 1'b0;
      end_song = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               addr_d  = start_addr_i;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (rom_dur == '0) begin
               end_song = 1'b1;
            end else begin
               note_d  = rom_note;
               dur_d   = rom_dur;
               step_d  = 1'b1;
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (tick) begin
               if (dur_q <= DUR_ONE) begin
                  dur_d = '0;
                  // Running off the top of the table ends the song rather than wrapping.
                  if (addr_q == ADDR_LAST) begin
                     end_song = 1'b1;
                  end else begin
                     addr_d  = addr_q + ADDR_ONE;
                     state_d = ST_FETCH;
                  end
               end else begin
                  dur_d = dur_q - DUR_ONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
      endcase

      if (end_song) begin
         note_d = '0;
         dur_d  = '0;
         if (loop_req) begin
            addr_d  = start_addr_i;
            state_d = ST_FETCH;
         end else begin
            state_d = ST_DONE;
         end
      end

      if (stop_i) begin
         state_d = ST_IDLE;
         note_d  = '0;
         dur_d   = '0;
         step_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         note_q  <= '0;
         dur_q   <= '0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         note_q  <= note_d;
         dur_q   <= dur_d;
         step_q  <= step_d;
      end
   end

   assign rom_addr_o = addr_q;
   assign note_o     = note_q;
   assign note_on_o  = (state_q == ST_PLAY) && (note_q != '0);
   assign step_o     = step_q;
   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = (state_q == ST_DONE);

endmodule
